// File: rtl/alu_pipe_if.sv
// Handshake and operand bundle for alu_pipe. The master drives operations and
// accepts results; the slave is the ALU itself.
interface alu_pipe_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [2:0]       func_class;
  logic [1:0]       shift_func;
  logic [1:0]       logic_func;
  logic             add_sub;
  logic             const_var;
  logic [SHW-1:0]   const_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             zero;
  logic             ovfl;
  logic             clr_sticky;
  logic             sticky_ovfl;

  modport master (
    output in_valid, x, y, func_class, shift_func, logic_func, add_sub,
           const_var, const_amt, out_ready, clr_sticky,
    input  in_ready, out_valid, s, zero, ovfl, sticky_ovfl
  );

  modport slave (
    input  in_valid, x, y, func_class, shift_func, logic_func, add_sub,
           const_var, const_amt, out_ready, clr_sticky,
    output in_ready, out_valid, s, zero, ovfl, sticky_ovfl
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU: single-cycle shift/compare/add/logic classes and
// an iterative shift-add multiplier that stalls the input while it runs.
module alu_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  alu_pipe_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                   state_q;
  logic        [SHW-1:0]    cnt_q;
  logic        [WIDTH-1:0]  mcand_q, mplier_q, acc_q;
  logic        [WIDTH-1:0]  s_q;
  logic                     zero_q, ovfl_q, vld_q, sticky_q;

  logic                     out_free, accept, is_mul, ld_single, ld_mul, load;
  logic        [SHW-1:0]    amt;
  logic        [WIDTH-1:0]  y_eff, sum, res_s, s_d;
  logic                     add_ovf, res_ovfl, ovfl_d;
  logic signed [WIDTH-1:0]  xs, ys;

  assign xs        = bus.x;
  assign ys        = bus.y;
  assign out_free  = !vld_q || bus.out_ready;
  assign bus.in_ready = !rst && (state_q == S_IDLE) && out_free;
  assign accept    = bus.in_valid && bus.in_ready;
  assign is_mul    = (bus.func_class == 3'b100);
  assign ld_single = accept && !is_mul;
  assign ld_mul    = (state_q == S_DONE) && out_free;
  assign load      = ld_single || ld_mul;

  // Subtraction reuses the adder as x + ~y + 1.
  always_comb begin
    amt      = bus.const_var ? bus.x[SHW-1:0] : bus.const_amt;
    y_eff    = bus.add_sub ? ~bus.y : bus.y;
    sum      = bus.x + y_eff + WIDTH'(bus.add_sub);
    add_ovf  = (bus.x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]);
    res_s    = '0;
    res_ovfl = 1'b0;
    case (bus.func_class)
      3'b000: begin
        case (bus.shift_func)
          2'b00:   res_s = bus.y;
          2'b01:   res_s = bus.y << amt;
          2'b10:   res_s = bus.y >> amt;
          default: res_s = ys >>> amt;
        endcase
      end
      3'b001: res_s[0] = (xs < ys);
      3'b010: begin
        res_s    = sum;
        res_ovfl = add_ovf;
      end
      3'b011: begin
        case (bus.logic_func)
          2'b00:   res_s = bus.x & bus.y;
          2'b01:   res_s = bus.x | bus.y;
          2'b10:   res_s = bus.x ^ bus.y;
          default: res_s = ~(bus.x | bus.y);
        endcase
      end
      3'b101: res_s[0] = (bus.x < bus.y);
      default: res_s = '0;
    endcase
    s_d    = ld_mul ? acc_q : res_s;
    ovfl_d = ld_mul ? 1'b0 : res_ovfl;
  end

  // Multiplier FSM: one multiplier bit per cycle, product parked in DONE until the output frees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && is_mul) begin
            mcand_q  <= bus.x;
            mplier_q <= bus.y;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_free) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      s_q      <= '0;
      zero_q   <= 1'b1;
      ovfl_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (load) begin
        s_q    <= s_d;
        zero_q <= (s_d == '0);
        ovfl_q <= ovfl_d;
      end
      if (load)               vld_q <= 1'b1;
      else if (bus.out_ready) vld_q <= 1'b0;
      if (load && ovfl_d)      sticky_q <= 1'b1;
      else if (bus.clr_sticky) sticky_q <= 1'b0;
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.s           = s_q;
  assign bus.zero        = zero_q;
  assign bus.ovfl        = ovfl_q;
  assign bus.sticky_ovfl = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe, checked against a queue-based
// arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] s;
    logic         z;
    logic         ov;
  } res_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  logic sticky_m;
  res_t exp_q[$];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic res_t ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [2:0] fc, input logic [1:0] sf,
                                   input logic [1:0] lf, input logic as,
                                   input logic cv, input logic [4:0] ca);
    res_t        r;
    int          amt;
    longint      sx, sy, sum;
    logic [63:0] p;
    r.s  = '0;
    r.ov = 1'b0;
    amt  = cv ? int'(x % 32) : int'(ca);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    case (fc)
      3'd0: begin
        case (sf)
          2'd0:    r.s = y;
          2'd1:    r.s = y << amt;
          2'd2:    r.s = y >> amt;
          default: r.s = (y >> amt) | (y[31] ? ~(32'hFFFFFFFF >> amt) : 32'h0);
        endcase
      end
      3'd1: r.s = (sx < sy) ? 32'd1 : 32'd0;
      3'd2: begin
        sum  = as ? (sx - sy) : (sx + sy);
        r.s  = sum[31:0];
        r.ov = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
      end
      3'd3: begin
        case (lf)
          2'd0:    r.s = x & y;
          2'd1:    r.s = x | y;
          2'd2:    r.s = x ^ y;
          default: r.s = ~(x | y);
        endcase
      end
      3'd4: begin
        p   = {32'h0, x} * {32'h0, y};
        r.s = p[31:0];
      end
      3'd5: r.s = (x < y) ? 32'd1 : 32'd0;
      default: r.s = '0;
    endcase
    r.z = (r.s == '0);
    return r;
  endfunction

  task automatic set_op(input logic [2:0] fc, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [1:0] sf, input logic [1:0] lf, input logic as,
                        input logic cv, input logic [4:0] ca);
    bus.in_valid   = 1'b1;
    bus.func_class = fc;
    bus.x          = x;
    bus.y          = y;
    bus.shift_func = sf;
    bus.logic_func = lf;
    bus.add_sub    = as;
    bus.const_var  = cv;
    bus.const_amt  = ca;
  endtask

  // One clock: settle, book handshakes against the model, cross the edge, return at negedge.
  task automatic cyc();
    res_t         r;
    logic         nxt_st;
    logic         stalled;
    logic [W-1:0] held;
    #1;
    nxt_st = sticky_m;
    if (rst) begin
      exp_q.delete();
      nxt_st = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          r = exp_q.pop_front();
          chk("s", bus.s, r.s);
          chk("zero", bus.zero, r.z);
          chk("ovfl", bus.ovfl, r.ov);
        end
      end
      if (bus.clr_sticky) nxt_st = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        r = ref_alu(bus.x, bus.y, bus.func_class, bus.shift_func, bus.logic_func,
                    bus.add_sub, bus.const_var, bus.const_amt);
        exp_q.push_back(r);
        if (r.ov) nxt_st = 1'b1;
      end
    end
    stalled = bus.out_valid && !bus.out_ready && !rst;
    held    = bus.s;
    @(posedge clk);
    sticky_m = nxt_st;
    @(negedge clk);
    chk("sticky", bus.sticky_ovfl, sticky_m);
    if (stalled) chk("hold_s", bus.s, held);
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h7FFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   n;
    logic irb;
    logic [2:0] fc;
    n_chk = 0;
    n_err = 0;
    sticky_m = 1'b0;
    rst = 1'b1;
    set_op(3'd0, '0, '0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_ovfl", bus.ovfl, 0);
    chk("rst_sticky", bus.sticky_ovfl, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Add overflow, then clear sticky
    bus.out_ready = 1'b0;
    set_op(3'd2, 32'h7FFFFFFF, 32'd1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    chk("addovf_s", bus.s, 32'h80000000);
    chk("addovf_ovfl", bus.ovfl, 1);
    chk("addovf_zero", bus.zero, 0);
    chk("addovf_sticky", bus.sticky_ovfl, 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.clr_sticky = 1'b1;
    cyc();
    bus.clr_sticky = 1'b0;
    chk("clr_sticky", bus.sticky_ovfl, 0);

    // Sub to zero, SLT vs SLTU, variable and constant ASR
    set_op(3'd2, 32'd5, 32'd5, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0);
    cyc();
    chk("sub_s", bus.s, 0);
    chk("sub_zero", bus.zero, 1);
    chk("sub_ovfl", bus.ovfl, 0);
    set_op(3'd1, 32'd1, 32'hFFFFFFFF, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    chk("slt_s", bus.s, 0);
    set_op(3'd5, 32'd1, 32'hFFFFFFFF, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    chk("sltu_s", bus.s, 1);
    set_op(3'd0, 32'h24, 32'h80000000, 2'd3, 2'd0, 1'b0, 1'b1, 5'd0);
    cyc();
    chk("asr_var_s", bus.s, 32'hF8000000);
    set_op(3'd0, 32'h24, 32'h80000000, 2'd3, 2'd0, 1'b0, 1'b0, 5'd31);
    cyc();
    chk("asr_const_s", bus.s, 32'hFFFFFFFF);

    // MUL latency and input stall
    set_op(3'd4, 32'hFFFFFFFD, 32'd7, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    bus.in_valid = 1'b0;
    n = 0;
    irb = 1'b0;
    while (!bus.out_valid && n < 60) begin
      bus.x = $urandom;
      bus.y = $urandom;
      #1;
      if (bus.in_ready) irb = 1'b1;
      cyc();
      n++;
    end
    chk("mul_latency", n, W + 1);
    chk("mul_in_ready_low", irb, 0);
    chk("mul_s", bus.s, 32'hFFFFFFEB);
    chk("mul_ovfl", bus.ovfl, 0);
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    chk("mul_held_s", bus.s, 32'hFFFFFFEB);
    bus.out_ready = 1'b1;
    cyc();

    // Backpressure ordering
    bus.out_ready = 1'b0;
    set_op(3'd2, 32'd1, 32'd2, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    chk("bp_first_s", bus.s, 3);
    set_op(3'd3, 32'hF0, 32'hFF, 2'd0, 2'd2, 1'b0, 1'b0, 5'd0);
    #1;
    chk("bp_in_ready_low", bus.in_ready, 0);
    cyc();
    chk("bp_still_3", bus.s, 3);
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_second_s", bus.s, 32'h0F);
    chk("bp_second_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    cyc();

    // Reset mid-multiply with sticky previously set
    set_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    set_op(3'd4, 32'h12345, 32'h6789, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    bus.in_valid = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_s", bus.s, 0);
    chk("midrst_zero", bus.zero, 1);
    chk("midrst_sticky", bus.sticky_ovfl, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", bus.in_ready, 1);
    set_op(3'd2, 32'd2, 32'd2, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    chk("postrst_add_s", bus.s, 4);
    bus.in_valid = 1'b0;
    repeat (40) cyc();

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      fc = 3'($urandom_range(0, 7));
      if (fc == 3'd4 && $urandom_range(0, 3) != 0) fc = 3'd2;
      set_op(fc, rnd_opnd(), rnd_opnd(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 9) < 7);
      bus.clr_sticky = ($urandom_range(0, 9) == 0);
      #1;
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
      cyc();
    end

    bus.in_valid = 1'b0;
    bus.clr_sticky = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      cyc();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
